monitor_contador16: RTL and testbench
=====================================

# monitor_contador16

Self-checking monitor for the 16-bit cascaded counter. It receives the same `enb`/`modo`/`D` stimulus the counter receives, plus the counter's `Q` and final-stage carry. It keeps a cycle-accurate reference model, compares the counter against it every clock, and reports mismatches as a pulse, a sticky flag, a saturating count and a captured snapshot. It is instantiated in testbenches and in the gate-level/delay-annotated regression, next to the synthesized counter.

## Interface
Parameters
- `ERR_W`, 8: width of the error counter.
- `RESYNC`, 1: 1 = return to SYNC after a mismatch; 0 = adopt the observed `Q` and keep tracking.

Ports
- `clk`, in, 1: single clock, same edge as the counter.
- `reset`, in, 1: synchronous, active-high.
- `enb`, in, 1: counter enable, exactly as driven to the counter.
- `modo`, in, 2: counter mode, exactly as driven to the counter.
- `D`, in, 16: parallel-load data, exactly as driven to the counter.
- `Q`, in, 16: counter output.
- `RCO`, in, 1: carry of the most significant stage, `RCO[3]`.
- `sincronizado`, out, 1: model is tracking.
- `error`, out, 1: one-cycle mismatch pulse.
- `error_pegajoso`, out, 1: sticky error.
- `cuenta_errores`, out, `ERR_W`: mismatch count, saturating.
- `q_esperado`, out, 16: model value.
- `q_error`, out, 16: `Q` captured at the first mismatch.

## Operation
Model update. At every edge with `enb`=1, the next model value M' and expected carry R' are computed from M:
- `modo`=00: M+1 mod 2^16. R'=1 only when M=FFFF.
- `modo`=01: M−1 mod 2^16. R'=1 only when M=0000.
- `modo`=10: M−3 mod 2^16. R'=1 only when M<3.
- `modo`=11: M'=D, R'=0.
- `enb`=0: M'=M, R'=0.

States:
- SYNC (reset state):
  - No comparison is made.
  - An edge with `enb`=1 and `modo`=11 sets M=D and R=0, then moves to TRACK.
  - `sincronizado` goes to 1 at that same edge.
- TRACK:
  - At every edge, compare `Q` against M and `RCO` against R.
  - Any difference is a mismatch.
  - The model is updated in the same edge.
- Mismatch handling in TRACK:
  - `error`=1 for exactly one cycle.
  - `error_pegajoso`=1 until reset.
  - `cuenta_errores` increments, holding at 2^ERR_W−1.
  - `q_error` is written only when `error_pegajoso` was 0 before the edge.
  - With RESYNC=1: go to SYNC and set `sincronizado`=0. Exception: if that same edge has `enb`=1 and `modo`=11, the load wins, M=D, and the state stays TRACK.
  - With RESYNC=0: compute M' from the observed `Q` instead of M and stay in TRACK.

Reset values: state SYNC; M=0000; R=0; all outputs 0.

## Timing
- The counter registers its inputs at edge k. The monitor updates M with the same inputs at edge k. At edge k+1 the monitor compares the counter's post-k `Q`/`RCO` with M/R. Zero added latency: model and counter advance in lockstep.
- `error` is registered. It is high in the cycle following the sampling edge that detected the mismatch.
- `q_esperado` shows M (registered). It matches `Q` in every cycle while TRACK is error-free.
- A `reset` asserted mid-operation clears everything at that edge. Inputs at that edge are ignored, including any load. The first load may occur at the next edge.
- `RCO` is compared only in TRACK, never in SYNC.
- The saturating counter never wraps.

## Test plan
- Reset, then load `D`=FFFD, then `modo`=00 for 4 cycles. Expected `Q` sequence: FFFE, FFFF, 0000 with `RCO`=1, then 0001 with `RCO`=0. Required response: `error` stays 0 and `sincronizado`=1 throughout.
- Load 0002, then `modo`=10 for 2 cycles. Required: M goes FFFF with R=1, then FFFC with R=0. No error against a correct counter.
- Load 1234, then force `Q`=1236 for one cycle with `modo`=01. Required: exactly one `error` pulse, `q_error`=1236, `cuenta_errores`=1, `error_pegajoso`=1. With RESYNC=1, `sincronizado`=0 until the next load.
- Drive 300 consecutive mismatches (RESYNC=0, ERR_W=8). Required: `cuenta_errores` saturates at FF. `q_error` keeps the first bad value.
- Mismatch edge with a simultaneous `modo`=11, `D`=00AA (RESYNC=1). Required: `error` pulses, the state stays TRACK, and M=00AA.
- `enb`=0 for 5 cycles while TRACK. Required: M holds and R=0. Then assert `reset` while `modo`=11. Required: all outputs go to 0 and the state is SYNC with no load taken.

Source files
------------

// File: rtl/monitor_contador16.sv
// Lockstep reference monitor for the 16-bit cascaded counter: tracks the expected
// Q/RCO every clock and reports mismatches as pulse, sticky flag, count and snapshot.
module monitor_contador16 #(
  parameter int ERR_W  = 8,
  parameter bit RESYNC = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [15:0]      D,
  input  logic [15:0]      Q,
  input  logic             RCO,
  output logic             sincronizado,
  output logic             error,
  output logic             error_pegajoso,
  output logic [ERR_W-1:0] cuenta_errores,
  output logic [15:0]      q_esperado,
  output logic [15:0]      q_error
);

  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [15:0]       m_r, m_s;
  logic              r_r, r_s;
  logic              error_r, error_s;
  logic              pegajoso_r, pegajoso_s;
  logic [ERR_W-1:0]  cuenta_r, cuenta_s;
  logic [15:0]       qerr_r, qerr_s;
  logic              mis_s;
  logic              load_s;
  logic [15:0]       base_s;
  logic [16:0]       nxt_s;

  // Counter behaviour for one edge: returns {carry, next value}.
  function automatic logic [16:0] paso(input logic [15:0] v, input logic e,
                                       input logic [1:0] md, input logic [15:0] d);
    logic [16:0] res;
    res = {1'b0, v};
    if (e) begin
      case (md)
        2'b00:   res = {(v == 16'hFFFF), v + 16'd1};
        2'b01:   res = {(v == 16'h0000), v - 16'd1};
        2'b10:   res = {(v < 16'd3), v - 16'd3};
        2'b11:   res = {1'b0, d};
        default: res = {1'b0, v};
      endcase
    end else begin
      res = {1'b0, v};
    end
    return res;
  endfunction

  // Next-state, model update and mismatch bookkeeping.
  always_comb begin
    state_s    = state_r;
    m_s        = m_r;
    r_s        = r_r;
    error_s    = 1'b0;
    pegajoso_s = pegajoso_r;
    cuenta_s   = cuenta_r;
    qerr_s     = qerr_r;
    mis_s      = 1'b0;
    load_s     = enb && (modo == 2'b11);
    base_s     = m_r;
    nxt_s      = {r_r, m_r};
    case (state_r)
      SYNC: begin
        r_s = 1'b0;
        if (load_s) begin
          state_s = TRACK;
          m_s     = D;
        end else begin
          state_s = SYNC;
        end
      end
      TRACK: begin
        mis_s = (Q != m_r) || (RCO != r_r);
        if (mis_s) begin
          error_s    = 1'b1;
          pegajoso_s = 1'b1;
          if (cuenta_r != CNT_MAX) begin
            cuenta_s = cuenta_r + CNT_ONE;
          end else begin
            cuenta_s = cuenta_r;
          end
          // Only the first bad value is kept.
          if (!pegajoso_r) begin
            qerr_s = Q;
          end else begin
            qerr_s = qerr_r;
          end
        end else begin
          error_s = 1'b0;
        end
        if (mis_s && RESYNC && !load_s) begin
          state_s = SYNC;
          r_s     = 1'b0;
        end else begin
          base_s = (mis_s && !RESYNC) ? Q : m_r;
          nxt_s  = paso(base_s, enb, modo, D);
          m_s    = nxt_s[15:0];
          r_s    = nxt_s[16];
        end
      end
      default: begin
        state_s = SYNC;
        r_s     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= SYNC;
      m_r        <= 16'h0000;
      r_r        <= 1'b0;
      error_r    <= 1'b0;
      pegajoso_r <= 1'b0;
      cuenta_r   <= {ERR_W{1'b0}};
      qerr_r     <= 16'h0000;
    end else begin
      state_r    <= state_s;
      m_r        <= m_s;
      r_r        <= r_s;
      error_r    <= error_s;
      pegajoso_r <= pegajoso_s;
      cuenta_r   <= cuenta_s;
      qerr_r     <= qerr_s;
    end
  end

  assign sincronizado   = (state_r == TRACK);
  assign error          = error_r;
  assign error_pegajoso = pegajoso_r;
  assign cuenta_errores = cuenta_r;
  assign q_esperado     = m_r;
  assign q_error        = qerr_r;

endmodule

// File: tb/tb_monitor_contador16.sv
// Bench for monitor_contador16: an ideal counter drives two monitors (RESYNC=1 and 0),
// a behavioural model predicts their outputs and is checked every negedge.
module tb_monitor_contador16;

  logic        clk;
  logic        reset;
  logic        enb;
  logic [1:0]  modo;
  logic [15:0] D;
  logic [15:0] cq;
  logic        crco;
  logic        f0, f1;
  logic [15:0] fq0, fq1;
  logic [15:0] q0, q1;

  logic        sinc0, err0, peg0, sinc1, err1, peg1;
  logic [7:0]  cnt0, cnt1;
  logic [15:0] qe0, qerr0, qe1, qerr1;

  int checks = 0;
  int errors = 0;

  assign q0 = f0 ? fq0 : cq;
  assign q1 = f1 ? fq1 : cq;

  monitor_contador16 #(.ERR_W(8), .RESYNC(1'b0)) u_m0 (
    .clk(clk), .reset(reset), .enb(enb), .modo(modo), .D(D), .Q(q0), .RCO(crco),
    .sincronizado(sinc0), .error(err0), .error_pegajoso(peg0),
    .cuenta_errores(cnt0), .q_esperado(qe0), .q_error(qerr0));

  monitor_contador16 #(.ERR_W(8), .RESYNC(1'b1)) u_m1 (
    .clk(clk), .reset(reset), .enb(enb), .modo(modo), .D(D), .Q(q1), .RCO(crco),
    .sincronizado(sinc1), .error(err1), .error_pegajoso(peg1),
    .cuenta_errores(cnt1), .q_esperado(qe1), .q_error(qerr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sync;
    logic [15:0] m;
    logic        r;
    logic        err;
    logic        peg;
    logic [7:0]  cnt;
    logic [15:0] qerr;
  } mstate_t;

  mstate_t st [2];

  // Counter rule as 17-bit arithmetic: the carry/borrow lands in bit 16.
  function automatic logic [16:0] cstep(input logic [15:0] v, input logic e,
                                        input logic [1:0] md, input logic [15:0] d);
    logic [16:0] t;
    if (!e)              t = {1'b0, v};
    else if (md == 2'd0) t = {1'b0, v} + 17'd1;
    else if (md == 2'd1) t = {1'b0, v} - 17'd1;
    else if (md == 2'd2) t = {1'b0, v} - 17'd3;
    else                 t = {1'b0, d};
    return t;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic rs, input logic e,
                                         input logic [1:0] md, input logic [15:0] d,
                                         input logic [15:0] q, input logic rc);
    mstate_t n;
    logic mis;
    logic [16:0] nx;
    n = s;
    n.err = 1'b0;
    if (!s.sync) begin
      if (e && md == 2'd3) begin
        n.sync = 1'b1; n.m = d; n.r = 1'b0;
      end
    end else begin
      mis = (q != s.m) || (rc != s.r);
      n.err = mis;
      if (mis) begin
        n.peg = 1'b1;
        n.cnt = (s.cnt == 8'hFF) ? 8'hFF : s.cnt + 8'd1;
        if (!s.peg) n.qerr = q;
      end
      if (mis && rs && !(e && md == 2'd3)) begin
        n.sync = 1'b0; n.r = 1'b0;
      end else begin
        nx = cstep((mis && !rs) ? q : s.m, e, md, d);
        n.m = nx[15:0];
        n.r = nx[16];
      end
    end
    return n;
  endfunction

  // Ideal counter and reference model both advance on the rising edge.
  always @(posedge clk) begin
    if (reset) begin
      {crco, cq} <= 17'd0;
      st[0] <= '0;
      st[1] <= '0;
    end else begin
      {crco, cq} <= cstep(cq, enb, modo, D);
      st[0] <= model_next(st[0], 1'b0, enb, modo, D, q0, crco);
      st[1] <= model_next(st[1], 1'b1, enb, modo, D, q1, crco);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic s, input logic e, input logic p,
                          input logic [7:0] c, input logic [15:0] qe, input logic [15:0] qr);
    mstate_t m;
    m = st[i];
    check($sformatf("i%0d.sincronizado", i), {31'd0, s}, {31'd0, m.sync});
    check($sformatf("i%0d.error", i), {31'd0, e}, {31'd0, m.err});
    check($sformatf("i%0d.error_pegajoso", i), {31'd0, p}, {31'd0, m.peg});
    check($sformatf("i%0d.cuenta_errores", i), {24'd0, c}, {24'd0, m.cnt});
    check($sformatf("i%0d.q_error", i), {16'd0, qr}, {16'd0, m.qerr});
    if (m.sync) check($sformatf("i%0d.q_esperado", i), {16'd0, qe}, {16'd0, m.m});
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cmp_inst(0, sinc0, err0, peg0, cnt0, qe0, qerr0);
    cmp_inst(1, sinc1, err1, peg1, cnt1, qe1, qerr1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    st[0] = '0; st[1] = '0;
    reset = 1'b1; enb = 1'b0; modo = 2'd0; D = 16'h0000;
    f0 = 1'b0; f1 = 1'b0; fq0 = 16'h0000; fq1 = 16'h0000;
    tick(2);
    check("rst.sincronizado", {31'd0, sinc1}, 32'd0);
    check("rst.q_esperado", {16'd0, qe1}, 32'h0000);
    check("rst.cuenta", {24'd0, cnt1}, 32'd0);

    // Wrap through FFFF with carry.
    reset = 1'b0; enb = 1'b1; modo = 2'd3; D = 16'hFFFD;
    tick();
    check("load.sincronizado", {31'd0, sinc1}, 32'd1);
    check("load.q_esperado", {16'd0, qe1}, 32'h0000FFFD);
    modo = 2'd0;
    tick(3);
    check("wrap.q_esperado", {16'd0, qe1}, 32'h00000000);
    tick();
    check("wrap.q_esperado2", {16'd0, qe1}, 32'h00000001);
    check("wrap.pegajoso", {31'd0, peg1}, 32'd0);

    // Down by three through zero.
    modo = 2'd3; D = 16'h0002;
    tick();
    modo = 2'd2;
    tick();
    check("dec3.q_esperado", {16'd0, qe1}, 32'h0000FFFF);
    tick();
    check("dec3.q_esperado2", {16'd0, qe1}, 32'h0000FFFC);
    check("dec3.pegajoso", {31'd0, peg1}, 32'd0);

    // Single forced mismatch.
    modo = 2'd3; D = 16'h1234;
    tick();
    modo = 2'd1; f0 = 1'b1; f1 = 1'b1; fq0 = 16'h1236; fq1 = 16'h1236;
    tick();
    check("mis.error", {31'd0, err1}, 32'd1);
    check("mis.q_error", {16'd0, qerr1}, 32'h00001236);
    check("mis.cuenta", {24'd0, cnt1}, 32'd1);
    check("mis.pegajoso", {31'd0, peg1}, 32'd1);
    check("mis.sincronizado", {31'd0, sinc1}, 32'd0);
    f0 = 1'b0; f1 = 1'b0; enb = 1'b0;
    tick();
    check("mis.error_pulse", {31'd0, err1}, 32'd0);
    check("mis.still_unsync", {31'd0, sinc1}, 32'd0);
    check("mis.i0_cuenta", {24'd0, cnt0}, 32'd2);

    // Mismatch coinciding with a load.
    enb = 1'b1; modo = 2'd3; D = 16'h5000;
    tick();
    D = 16'h00AA; f1 = 1'b1; fq1 = 16'h1111;
    tick();
    check("mload.error", {31'd0, err1}, 32'd1);
    check("mload.sincronizado", {31'd0, sinc1}, 32'd1);
    check("mload.q_esperado", {16'd0, qe1}, 32'h000000AA);
    check("mload.q_error", {16'd0, qerr1}, 32'h00001236);
    f1 = 1'b0;

    // Hold, then reset with a pending load.
    enb = 1'b0;
    tick(5);
    check("hold.q_esperado", {16'd0, qe1}, 32'h000000AA);
    check("hold.error", {31'd0, err1}, 32'd0);
    reset = 1'b1; enb = 1'b1; modo = 2'd3; D = 16'h7777;
    tick();
    check("rst2.sincronizado", {31'd0, sinc1}, 32'd0);
    check("rst2.q_esperado", {16'd0, qe1}, 32'd0);
    check("rst2.cuenta", {24'd0, cnt1}, 32'd0);
    check("rst2.q_error", {16'd0, qerr1}, 32'd0);
    check("rst2.pegajoso", {31'd0, peg1}, 32'd0);
    reset = 1'b0; enb = 1'b0;
    tick();
    check("rst2.no_load", {31'd0, sinc1}, 32'd0);

    // Long mismatch burst saturates the count.
    enb = 1'b1; modo = 2'd3; D = 16'h0100;
    tick();
    modo = 2'd0; f0 = 1'b1; fq0 = 16'hDEAD; f1 = 1'b1; fq1 = 16'hDEAD;
    tick(300);
    check("sat.cuenta", {24'd0, cnt0}, 32'h000000FF);
    check("sat.q_error", {16'd0, qerr0}, 32'h0000DEAD);
    check("sat.error", {31'd0, err0}, 32'd1);
    check("sat.sincronizado", {31'd0, sinc0}, 32'd1);
    f0 = 1'b0; f1 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
